// File: rtl/multiplicador_pkg.sv
// -----------------------------------------------------------------------------
// multiplicador_pkg
// Shared definitions for the floating-point mantissa multiplier and the
// exponent/sign assembly stage that follows it.
//   - ST_IDLE/ST_MULT/ST_NORM/ST_DONE : state encoding of the sequential core
//   - state_t                         : enum built on that encoding
//   - RND_TRUNC/RND_RNE               : values of the per-operation round mode
// -----------------------------------------------------------------------------
package multiplicador_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MULT = ST_MULT,
        NORM = ST_NORM,
        DONE = ST_DONE
    } state_t;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

endpackage

// File: rtl/normalizador_redondeo.sv
// -----------------------------------------------------------------------------
// normalizador_redondeo
// Combinational normalise-and-round stage for the product of two mantissas
// that both carry their implicit leading one (product value in [1,4)).
// Ports:
//   i_producto   : 2*NB_MANT+2 bit raw product
//   i_round_mode : RND_TRUNC truncates, RND_RNE rounds to nearest even
//   o_mantiza    : normalised, rounded mantissa field (implicit one dropped)
//   o_exp_inc    : exponent must be incremented by one
// -----------------------------------------------------------------------------
module normalizador_redondeo
    import multiplicador_pkg::*;
#(
    parameter int NB_MANT = 8
) (
    input  logic [2*NB_MANT+1:0] i_producto,
    input  logic                 i_round_mode,
    output logic [NB_MANT-1:0]   o_mantiza,
    output logic                 o_exp_inc
);

    logic [NB_MANT-1:0] mant_raw;
    logic               guard_bit;
    logic               sticky_bit;
    logic               exp_raw;
    logic               round_up;
    logic [NB_MANT:0]   mant_rnd;

    // The top product bit tells whether the product landed in [2,4); in that
    // case the field sits one position higher and the exponent grows by one.
    // Rounding is done on an extra carry bit: a carry out of an all-ones
    // mantissa leaves a zero field and pushes the exponent up instead. That
    // carry can only happen when the product was below 2, so the two
    // increment sources never both fire.
    always_comb begin
        exp_raw = i_producto[2*NB_MANT+1];
        if (exp_raw) begin
            mant_raw   = i_producto[2*NB_MANT -: NB_MANT];
            guard_bit  = i_producto[NB_MANT];
            sticky_bit = |i_producto[NB_MANT-1:0];
        end else begin
            mant_raw   = i_producto[2*NB_MANT-1 -: NB_MANT];
            guard_bit  = i_producto[NB_MANT-1];
            sticky_bit = |i_producto[NB_MANT-2:0];
        end
        round_up  = (i_round_mode == RND_RNE) && guard_bit && (sticky_bit || mant_raw[0]);
        mant_rnd  = {1'b0, mant_raw} + {{NB_MANT{1'b0}}, round_up};
        o_mantiza = mant_rnd[NB_MANT-1:0];
        o_exp_inc = exp_raw | mant_rnd[NB_MANT];
    end

endmodule

// File: rtl/multiplicador_mantiza_seq.sv
// -----------------------------------------------------------------------------
// multiplicador_mantiza_seq
// Iterative shift-add multiplier for floating-point mantissa fields. The
// implicit leading one is restored internally, the product is normalised and
// rounded (truncate or round-to-nearest-even per operation) and the block
// reports whether the exponent must be incremented.
// Ports:
//   clock, i_reset             : rising-edge clock, async active-high reset
//   i_valid / o_ready          : operand handshake (accepted only when idle)
//   i_mantiza_1, i_mantiza_2   : stored mantissa fields of the two operands
//   i_round_mode               : RND_TRUNC or RND_RNE
//   o_valid / i_ready          : result handshake
//   o_mantiza, o_exp_inc       : rounded mantissa field, exponent increment
// -----------------------------------------------------------------------------
module multiplicador_mantiza_seq
    import multiplicador_pkg::*;
#(
    parameter int NB_MANT = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_MANT-1:0] i_mantiza_1,
    input  logic [NB_MANT-1:0] i_mantiza_2,
    input  logic               i_round_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_MANT-1:0] o_mantiza,
    output logic               o_exp_inc
);

    localparam int NB_CNT  = $clog2(NB_MANT + 2);
    localparam int NB_PROD = 2 * NB_MANT + 2;
    // Index of the final iteration; the counter passes this value on the
    // edge that performs the last partial-product add.
    localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_MANT);

    state_t               state_q, state_d;
    logic [NB_MANT:0]     a_q, a_d;
    logic [NB_MANT:0]     b_q, b_d;
    logic                 modo_q, modo_d;
    logic [NB_PROD-1:0]   acc_q, acc_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [NB_MANT-1:0]   mant_q, mant_d;
    logic                 exp_inc_q, exp_inc_d;

    logic [NB_PROD-1:0]   a_shift;
    logic [NB_MANT-1:0]   norm_mant;
    logic                 norm_exp_inc;

    normalizador_redondeo #(
        .NB_MANT      (NB_MANT)
    ) u_normalizador (
        .i_producto   (acc_q),
        .i_round_mode (modo_q),
        .o_mantiza    (norm_mant),
        .o_exp_inc    (norm_exp_inc)
    );

    // Next-state and datapath logic. A is never shifted in place; instead it
    // is shifted by the iteration index each cycle, while B shifts right so
    // its LSB always selects the current partial product. Operand inputs are
    // only looked at in IDLE, so they may change freely during an operation.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        modo_d    = modo_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        mant_d    = mant_q;
        exp_inc_d = exp_inc_q;
        a_shift   = {{(NB_MANT+1){1'b0}}, a_q} << cnt_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = {1'b1, i_mantiza_1};
                    b_d     = {1'b1, i_mantiza_2};
                    modo_d  = i_round_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_shift;
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + NB_CNT'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                mant_d    = norm_mant;
                exp_inc_d = norm_exp_inc;
                valid_d   = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state lives here; reset aborts whatever operation is in flight and
    // drops any pending result.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            modo_q    <= RND_TRUNC;
            acc_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            mant_q    <= '0;
            exp_inc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            modo_q    <= modo_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            mant_q    <= mant_d;
            exp_inc_q <= exp_inc_d;
        end
    end

    // Ready is a pure state decode, so it never overlaps a result hand-off.
    assign o_ready   = (state_q == IDLE);
    assign o_valid   = valid_q;
    assign o_mantiza = mant_q;
    assign o_exp_inc = exp_inc_q;

endmodule

// File: tb/tb_multiplicador_mantiza_seq.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_mantiza_seq
// Self-checking bench for multiplicador_mantiza_seq with 8-bit mantissas:
// directed corner cases, handshake hold, mid-operation reset and random
// operations against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multiplicador_mantiza_seq;

    localparam int N       = 8;
    localparam int LATENCY = N + 2;

    logic         clock = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [N-1:0] i_mantiza_1 = '0;
    logic [N-1:0] i_mantiza_2 = '0;
    logic         i_round_mode = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [N-1:0] o_mantiza;
    logic         o_exp_inc;

    int checks = 0;
    int errors = 0;

    multiplicador_mantiza_seq #(
        .NB_MANT      (N)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mantiza_1  (i_mantiza_1),
        .i_mantiza_2  (i_mantiza_2),
        .i_round_mode (i_round_mode),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_mantiza    (o_mantiza),
        .o_exp_inc    (o_exp_inc)
    );

    // 100 MHz-style free-running clock
    always #5 clock = ~clock;

    // Reference model: exact integer product of 1.m1 * 1.m2, normalised by
    // comparing against 2.0 and rounded by comparing the discarded remainder
    // with one half ulp.
    function automatic void refModel(input logic [N-1:0] m1, input logic [N-1:0] m2,
                                     input logic mode,
                                     output logic [N-1:0] mant, output logic inc);
        int unsigned p, shift, rem, half, m;
        p = (32'd256 + 32'(m1)) * (32'd256 + 32'(m2));
        if (p >= 32'd131072) begin
            inc   = 1'b1;
            shift = 9;
        end else begin
            inc   = 1'b0;
            shift = 8;
        end
        m    = (p >> shift) - 32'd256;
        rem  = p % (32'd1 << shift);
        half = 32'd1 << (shift - 1);
        if (mode && ((rem > half) || ((rem == half) && (m % 2 == 1)))) begin
            m = m + 1;
        end
        if (m == 32'd256) begin
            m   = 0;
            inc = 1'b1;
        end
        mant = m[N-1:0];
    endfunction

    // One comparison: count it, and on a miss count the error and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operation, waits for the accept edge, scrambles the inputs
    // afterwards and counts edges until the result shows up (bounded).
    task automatic applyStimulus(input logic [N-1:0] m1, input logic [N-1:0] m2,
                                 input logic mode, output int latency);
        int waitCycles;
        waitCycles = 0;
        while (!o_ready && waitCycles < 50) begin
            @(posedge clock);
            #1;
            waitCycles++;
        end
        checkOutput("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid      = 1'b1;
        i_mantiza_1  = m1;
        i_mantiza_2  = m2;
        i_round_mode = mode;
        @(posedge clock);
        #1;
        i_valid      = 1'($urandom);
        i_mantiza_1  = N'($urandom);
        i_mantiza_2  = N'($urandom);
        i_round_mode = 1'($urandom);
        latency = 0;
        while (!o_valid && latency < 40) begin
            @(posedge clock);
            #1;
            latency++;
            i_valid = 1'($urandom);
        end
        i_valid = 1'b0;
    endtask

    // Accepts the pending result and checks the block returns to idle.
    task automatic releaseResult(input string tag);
        i_ready = 1'b1;
        @(posedge clock);
        #1;
        i_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    // Full operation with expected values supplied by the caller.
    task automatic runOp(input string tag, input logic [N-1:0] m1, input logic [N-1:0] m2,
                         input logic mode, input logic [N-1:0] expMant, input logic expInc);
        int latency;
        applyStimulus(m1, m2, mode, latency);
        checkOutput({tag, "_latency"}, 32'(latency), 32'(LATENCY));
        checkOutput({tag, "_mantiza"}, 32'(o_mantiza), 32'(expMant));
        checkOutput({tag, "_exp_inc"}, 32'(o_exp_inc), 32'(expInc));
        releaseResult(tag);
    endtask

    logic [N-1:0] dirM1   [10] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h6A, 8'h6A};
    logic [N-1:0] dirM2   [10] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h6A, 8'h6A};
    logic         dirMode [10] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [N-1:0] dirMant [10] = '{8'h00, 8'h00, 8'h20, 8'h20, 8'h81, 8'h82, 8'hFE, 8'hFE, 8'hFF, 8'h00};
    logic         dirInc  [10] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};

    initial begin
        logic [N-1:0] m1, m2, expMant;
        logic         mode, expInc;
        int           latency;

        // Reset state
        #12;
        checkOutput("reset_valid",   32'(o_valid),   32'd0);
        checkOutput("reset_mantiza", 32'(o_mantiza), 32'd0);
        checkOutput("reset_exp_inc", 32'(o_exp_inc), 32'd0);
        checkOutput("reset_ready",   32'(o_ready),   32'd1);
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed corner cases
        $display("[TB] directed vectors");
        for (int i = 0; i < 10; i++) begin
            runOp($sformatf("dir%0d", i), dirM1[i], dirM2[i], dirMode[i], dirMant[i], dirInc[i]);
        end

        // Result held while downstream stalls, inputs toggling meanwhile
        $display("[TB] handshake hold");
        m1   = 8'h35;
        m2   = 8'hC2;
        mode = 1'b1;
        refModel(m1, m2, mode, expMant, expInc);
        applyStimulus(m1, m2, mode, latency);
        checkOutput("hold_latency", 32'(latency), 32'(LATENCY));
        for (int c = 0; c < 5; c++) begin
            i_valid      = 1'($urandom);
            i_mantiza_1  = N'($urandom);
            i_mantiza_2  = N'($urandom);
            i_round_mode = 1'($urandom);
            @(posedge clock);
            #1;
            checkOutput($sformatf("hold%0d_valid", c),   32'(o_valid),   32'd1);
            checkOutput($sformatf("hold%0d_mantiza", c), 32'(o_mantiza), 32'(expMant));
            checkOutput($sformatf("hold%0d_exp_inc", c), 32'(o_exp_inc), 32'(expInc));
            checkOutput($sformatf("hold%0d_ready", c),   32'(o_ready),   32'd0);
        end
        i_valid = 1'b0;
        releaseResult("hold");
        @(posedge clock);
        #1;
        checkOutput("hold_no_second_accept", 32'(o_ready), 32'd1);

        // Reset in the middle of the multiply loop
        $display("[TB] reset during multiply");
        i_valid      = 1'b1;
        i_mantiza_1  = 8'hA7;
        i_mantiza_2  = 8'h5C;
        i_round_mode = 1'b0;
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        i_reset = 1'b1;
        #1;
        checkOutput("midrst_valid",   32'(o_valid),   32'd0);
        checkOutput("midrst_mantiza", 32'(o_mantiza), 32'd0);
        checkOutput("midrst_exp_inc", 32'(o_exp_inc), 32'd0);
        checkOutput("midrst_ready",   32'(o_ready),   32'd1);
        @(posedge clock);
        #1;
        i_reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        checkOutput("midrst_aborted", 32'(o_valid), 32'd0);
        refModel(8'hA7, 8'h5C, 1'b1, expMant, expInc);
        runOp("after_rst", 8'hA7, 8'h5C, 1'b1, expMant, expInc);

        // Random operations against the reference model
        $display("[TB] random operations");
        for (int r = 0; r < 24; r++) begin
            m1   = N'($urandom);
            m2   = N'($urandom);
            mode = 1'($urandom);
            refModel(m1, m2, mode, expMant, expInc);
            runOp($sformatf("rnd%0d", r), m1, m2, mode, expMant, expInc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
